// File: rtl/ascon_pkg.sv
// Shared types and constants for the ASCON-128 encryption control path.
// Round indices follow the ASCON constant table: a permutation of n rounds runs i = 12-n .. 11.
package ascon_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_AD_WAIT,
    S_AD_PERM,
    S_PT_WAIT,
    S_PT_PERM,
    S_FINAL,
    S_DONE
  } t_fsm_state;

  localparam int NB_ROUNDS_A_DEF = 12;
  localparam int NB_ROUNDS_B_DEF = 6;

  localparam logic [3:0] ROUND_LAST = 4'd11;

  function automatic logic [3:0] round_start(input int nb_rounds);
    return 4'(12 - nb_rounds);
  endfunction

endpackage

// File: rtl/ascon_round_counter.sv
// Loadable 4-bit round index; saturates at the last round so a stalled phase never wraps.
// Load has priority over increment; o_terminal flags the final round of any permutation.
module ascon_round_counter
  import ascon_pkg::*;
(
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_enable,
  output logic [3:0] o_count,
  output logic       o_terminal
);

  logic [3:0] count;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count <= 4'd0;
    end else if (i_load) begin
      count <= i_load_val;
    end else if (i_enable && (count != ROUND_LAST)) begin
      count <= count + 4'd1;
    end
  end

  assign o_count    = count;
  assign o_terminal = (count == ROUND_LAST);

endmodule

// File: rtl/ascon_fsm.sv
// ASCON-128 encryption sequencer: one permutation round per cycle, strobes are decodes of state/counter/handshake.
// Blocks in AD_WAIT/PT_WAIT until i_data_valid; a PT or AD block is consumed on the accept cycle itself.
module ascon_fsm
  import ascon_pkg::*;
#(
  parameter int NB_ROUNDS_A = NB_ROUNDS_A_DEF,
  parameter int NB_ROUNDS_B = NB_ROUNDS_B_DEF
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_start,
  input  logic       i_has_ad,
  input  logic       i_data_valid,
  input  logic       i_data_last,
  output logic       o_data_ready,
  output logic [3:0] o_round,
  output logic       o_state_load,
  output logic       o_state_enable,
  output logic       o_enable_xor_data_begin,
  output logic       o_enable_xor_key_begin,
  output logic       o_enable_xor_key_end,
  output logic       o_enable_xor_lsb_end,
  output logic       o_cipher_valid,
  output logic       o_tag_valid,
  output logic       o_busy
);

  localparam logic [3:0] A_START    = round_start(NB_ROUNDS_A);
  localparam logic [3:0] B_START    = round_start(NB_ROUNDS_B);
  localparam logic [3:0] A_START_P1 = A_START + 4'd1;
  localparam bit         A_SINGLE   = (NB_ROUNDS_A == 1);

  t_fsm_state state;
  t_fsm_state state_nxt;
  logic       has_ad;
  logic       blk_last;
  logic [3:0] cnt;
  logic       cnt_term;
  logic       cnt_load;
  logic [3:0] cnt_val;
  logic       cnt_inc;
  logic       start_acc;
  logic       data_wait;
  logic       accept;

  // Gating with reset keeps the load strobe quiet while reset is held with i_start high.
  assign start_acc = (state == S_IDLE) && i_start && i_reset_n;
  assign data_wait = (state == S_AD_WAIT) || (state == S_PT_WAIT);
  assign accept    = data_wait && i_data_valid;

  ascon_round_counter u_round_counter (
    .i_clock    (i_clock),
    .i_reset_n  (i_reset_n),
    .i_load     (cnt_load),
    .i_load_val (cnt_val),
    .i_enable   (cnt_inc),
    .o_count    (cnt),
    .o_terminal (cnt_term)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Phase context: AD presence for the INIT exit, last-flag of the AD block in flight.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      has_ad   <= 1'b0;
      blk_last <= 1'b0;
    end else begin
      if (start_acc) begin
        has_ad <= i_has_ad;
      end
      if ((state == S_AD_WAIT) && accept) begin
        blk_last <= i_data_last;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_val   = 4'd0;
    cnt_inc   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_acc) begin
          state_nxt = S_INIT;
          cnt_load  = 1'b1;
          cnt_val   = A_START;
        end
      end
      S_INIT: begin
        if (cnt_term) begin
          state_nxt = has_ad ? S_AD_WAIT : S_PT_WAIT;
          cnt_load  = 1'b1;
          cnt_val   = B_START;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_AD_WAIT: begin
        if (accept) begin
          if (cnt_term) begin
            state_nxt = i_data_last ? S_PT_WAIT : S_AD_WAIT;
            cnt_load  = 1'b1;
            cnt_val   = B_START;
          end else begin
            state_nxt = S_AD_PERM;
            cnt_inc   = 1'b1;
          end
        end
      end
      S_AD_PERM: begin
        if (cnt_term) begin
          state_nxt = blk_last ? S_PT_WAIT : S_AD_WAIT;
          cnt_load  = 1'b1;
          cnt_val   = B_START;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_PT_WAIT: begin
        if (accept) begin
          if (i_data_last) begin
            state_nxt = A_SINGLE ? S_DONE : S_FINAL;
            cnt_load  = 1'b1;
            cnt_val   = A_SINGLE ? 4'd0 : A_START_P1;
          end else if (cnt_term) begin
            cnt_load = 1'b1;
            cnt_val  = B_START;
          end else begin
            state_nxt = S_PT_PERM;
            cnt_inc   = 1'b1;
          end
        end
      end
      S_PT_PERM: begin
        if (cnt_term) begin
          state_nxt = S_PT_WAIT;
          cnt_load  = 1'b1;
          cnt_val   = B_START;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_FINAL: begin
        if (cnt_term) begin
          state_nxt = S_DONE;
          cnt_load  = 1'b1;
          cnt_val   = 4'd0;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    o_data_ready            = 1'b0;
    o_round                 = 4'd0;
    o_state_load            = 1'b0;
    o_state_enable          = 1'b0;
    o_enable_xor_data_begin = 1'b0;
    o_enable_xor_key_begin  = 1'b0;
    o_enable_xor_key_end    = 1'b0;
    o_enable_xor_lsb_end    = 1'b0;
    o_cipher_valid          = 1'b0;
    o_tag_valid             = 1'b0;
    o_busy                  = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        o_state_load   = start_acc;
        o_state_enable = start_acc;
      end
      S_INIT: begin
        o_round        = cnt;
        o_state_enable = 1'b1;
        if (cnt_term) begin
          o_enable_xor_key_end = 1'b1;
          o_enable_xor_lsb_end = !has_ad;
        end
      end
      S_AD_WAIT: begin
        o_data_ready = 1'b1;
        o_round      = cnt;
        if (accept) begin
          o_state_enable          = 1'b1;
          o_enable_xor_data_begin = 1'b1;
          o_enable_xor_lsb_end    = cnt_term && i_data_last;
        end
      end
      S_AD_PERM: begin
        o_round              = cnt;
        o_state_enable       = 1'b1;
        o_enable_xor_lsb_end = cnt_term && blk_last;
      end
      S_PT_WAIT: begin
        o_data_ready = 1'b1;
        o_round      = cnt;
        if (accept) begin
          o_state_enable          = 1'b1;
          o_enable_xor_data_begin = 1'b1;
          o_cipher_valid          = 1'b1;
          // Last plaintext block folds the key in and starts the finalisation permutation.
          if (i_data_last) begin
            o_round                = A_START;
            o_enable_xor_key_begin = 1'b1;
            o_enable_xor_key_end   = A_SINGLE;
          end
        end
      end
      S_PT_PERM: begin
        o_round        = cnt;
        o_state_enable = 1'b1;
      end
      S_FINAL: begin
        o_round              = cnt;
        o_state_enable       = 1'b1;
        o_enable_xor_key_end = cnt_term;
      end
      S_DONE: begin
        o_tag_valid = 1'b1;
      end
      default: begin
        o_busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ascon_fsm.sv
// Directed checks of the ASCON sequencer timeline with default round counts (p_a = 12, p_b = 6).
// Inputs change 1 time unit after each rising edge; outputs are sampled 1 unit later.
module tb_ascon_fsm;

  logic       i_clock;
  logic       i_reset_n;
  logic       i_start;
  logic       i_has_ad;
  logic       i_data_valid;
  logic       i_data_last;
  logic       o_data_ready;
  logic [3:0] o_round;
  logic       o_state_load;
  logic       o_state_enable;
  logic       o_enable_xor_data_begin;
  logic       o_enable_xor_key_begin;
  logic       o_enable_xor_key_end;
  logic       o_enable_xor_lsb_end;
  logic       o_cipher_valid;
  logic       o_tag_valid;
  logic       o_busy;

  int n_vec;
  int n_err;

  ascon_fsm dut (
    .i_clock                 (i_clock),
    .i_reset_n               (i_reset_n),
    .i_start                 (i_start),
    .i_has_ad                (i_has_ad),
    .i_data_valid            (i_data_valid),
    .i_data_last             (i_data_last),
    .o_data_ready            (o_data_ready),
    .o_round                 (o_round),
    .o_state_load            (o_state_load),
    .o_state_enable          (o_state_enable),
    .o_enable_xor_data_begin (o_enable_xor_data_begin),
    .o_enable_xor_key_begin  (o_enable_xor_key_begin),
    .o_enable_xor_key_end    (o_enable_xor_key_end),
    .o_enable_xor_lsb_end    (o_enable_xor_lsb_end),
    .o_cipher_valid          (o_cipher_valid),
    .o_tag_valid             (o_tag_valid),
    .o_busy                  (o_busy)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  // Word layout: round[13:10] load en data_begin key_begin key_end lsb_end cipher_valid tag_valid busy ready.
  // rnd < 0 leaves o_round unchecked.
  task automatic chk(input string tag, input int rnd,
                     input bit ld, input bit en, input bit db, input bit kb, input bit ke,
                     input bit le, input bit cv, input bit tv, input bit bsy, input bit rdy);
    logic [13:0] obs;
    logic [13:0] exp;
    logic [13:0] msk;
    #1;
    obs = {o_round, o_state_load, o_state_enable, o_enable_xor_data_begin, o_enable_xor_key_begin,
           o_enable_xor_key_end, o_enable_xor_lsb_end, o_cipher_valid, o_tag_valid, o_busy, o_data_ready};
    exp = {(rnd < 0) ? 4'h0 : 4'(rnd), ld, en, db, kb, ke, le, cv, tv, bsy, rdy};
    msk = {(rnd < 0) ? 4'h0 : 4'hf, 10'h3ff};
    n_vec++;
    assert ((obs & msk) === (exp & msk)) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs & msk, exp & msk);
    end
  endtask

  task automatic start_seq(input string p, input bit has_ad);
    i_start  = 1'b1;
    i_has_ad = has_ad;
    chk({p, ".start"}, -1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    i_start = 1'b0;
  endtask

  task automatic init_seq(input string p, input bit has_ad);
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("%s.init%0d", p, k), k, 0, 1, 0, 0, k == 11, (k == 11) && !has_ad, 0, 0, 1, 0);
      tick();
    end
  endtask

  task automatic accept_b(input string p, input bit is_pt, input bit last);
    i_data_valid = 1'b1;
    i_data_last  = last;
    chk({p, ".accept"}, 6, 0, 1, 1, 0, 0, 0, is_pt, 0, 1, 1);
    tick();
    i_data_valid = 1'b0;
    i_data_last  = 1'b0;
  endtask

  task automatic perm_b(input string p, input bit lsb_last);
    for (int r = 7; r < 12; r++) begin
      chk($sformatf("%s.permb%0d", p, r), r, 0, 1, 0, 0, 0, (r == 11) && lsb_last, 0, 0, 1, 0);
      tick();
    end
  endtask

  task automatic accept_final(input string p);
    i_data_valid = 1'b1;
    i_data_last  = 1'b1;
    chk({p, ".ptlast"}, 0, 0, 1, 1, 1, 0, 0, 1, 0, 1, 1);
    tick();
    i_data_valid = 1'b0;
    i_data_last  = 1'b0;
  endtask

  task automatic final_done(input string p);
    for (int r = 1; r < 12; r++) begin
      chk($sformatf("%s.final%0d", p, r), r, 0, 1, 0, 0, r == 11, 0, 0, 0, 1, 0);
      tick();
    end
    chk({p, ".done"}, -1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    tick();
    chk({p, ".idle"}, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    i_reset_n    = 1'b0;
    i_start      = 1'b1;
    i_has_ad     = 1'b0;
    i_data_valid = 1'b0;
    i_data_last  = 1'b0;

    // Reset with i_start held high: everything quiet, counter at 0.
    #2;
    chk("rst.hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("rst.edge", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    i_start   = 1'b0;
    i_reset_n = 1'b1;
    tick();
    chk("rst.idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // No AD, single PT block presented ahead of time (also ignored during INIT).
    i_data_valid = 1'b1;
    i_data_last  = 1'b1;
    start_seq("A", 1'b0);
    init_seq("A", 1'b0);
    accept_final("A");
    final_done("A");

    // Two AD blocks, one PT; i_start pulse during AD_PERM and valid during INIT are ignored.
    start_seq("B", 1'b1);
    i_data_valid = 1'b1;
    init_seq("B", 1'b1);
    accept_b("B.ad0", 1'b0, 1'b0);
    i_data_valid = 1'b1;
    i_start      = 1'b1;
    perm_b("B.ad0", 1'b0);
    i_start      = 1'b0;
    i_data_valid = 1'b0;
    accept_b("B.ad1", 1'b0, 1'b1);
    perm_b("B.ad1", 1'b1);
    accept_final("B");
    final_done("B");

    // PT_WAIT stall for 5 cycles, then one non-last and one last PT block.
    start_seq("C", 1'b0);
    init_seq("C", 1'b0);
    for (int s = 0; s < 5; s++) begin
      chk($sformatf("C.stall%0d", s), 6, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      tick();
    end
    accept_b("C.pt0", 1'b1, 1'b0);
    perm_b("C.pt0", 1'b0);
    accept_final("C");
    final_done("C");

    // Reset during FINAL round 5, then a clean rerun of the no-AD timeline.
    start_seq("D", 1'b0);
    init_seq("D", 1'b0);
    accept_final("D");
    for (int r = 1; r < 5; r++) begin
      chk($sformatf("D.final%0d", r), r, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
      tick();
    end
    i_data_valid = 1'b1;
    i_data_last  = 1'b1;
    chk("D.final5", 5, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    i_reset_n = 1'b0;
    chk("D.rst_async", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("D.rst_held", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    i_reset_n = 1'b1;
    tick();
    chk("D.rst_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    start_seq("E", 1'b0);
    init_seq("E", 1'b0);
    accept_final("E");
    final_done("E");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ascon_fsm.md
ASCON_FSM -- requirements
Module: ascon_fsm

Interface
REQ-001 Parameter NB_ROUNDS_A, default 12: rounds of permutation p_a (initialisation, finalisation).
REQ-002 Parameter NB_ROUNDS_B, default 6: rounds of permutation p_b (AD/plaintext blocks).
REQ-003 i_clock  in  1  single clock; all state changes on rising edge.
REQ-004 i_reset_n  in  1  asynchronous, active-low reset.
REQ-005 i_start  in  1  start a new encryption; sampled only in IDLE.
REQ-006 i_has_ad  in  1  associated data present; sampled with i_start.
REQ-007 i_data_valid  in  1  64-bit AD/plaintext block available on datapath input.
REQ-008 i_data_last  in  1  qualifies i_data_valid: final block of current phase (AD or PT).
REQ-009 o_data_ready  out  1  block accepted when o_data_ready and i_data_valid both high.
REQ-010 o_round  out  4  round-constant index i for current permutation round.
REQ-011 o_state_load  out  1  state register loads IV||K||N instead of round output.
REQ-012 o_state_enable  out  1  state register write enable.
REQ-013 o_enable_xor_data_begin / o_enable_xor_key_begin  out  1 each  drive data/key XOR ahead of the round.
REQ-014 o_enable_xor_key_end / o_enable_xor_lsb_end  out  1 each  drive key XOR / domain-separation LSB XOR after the round.
REQ-015 o_cipher_valid  out  1  ciphertext block valid (same cycle as PT acceptance).
REQ-016 o_tag_valid  out  1  one-cycle pulse: tag valid in state words 3-4.
REQ-017 o_busy  out  1  high in every state except IDLE.

Function
REQ-018 States: IDLE, INIT, AD_WAIT, AD_PERM, PT_WAIT, PT_PERM, FINAL, DONE; one round per cycle in *_PERM/INIT/FINAL.
REQ-019 IDLE: on i_start, pulse o_state_load+o_state_enable, latch i_has_ad, go INIT, round counter = 12-NB_ROUNDS_A.
REQ-020 INIT: NB_ROUNDS_A cycles, o_round 0..11, o_state_enable high; last round asserts o_enable_xor_key_end.
REQ-021 INIT exit: has_ad -> AD_WAIT; else -> PT_WAIT with o_enable_xor_lsb_end also asserted on INIT last round.
REQ-022 AD_WAIT/PT_WAIT: o_data_ready high, o_state_enable low until handshake; state held indefinitely.
REQ-023 Accept cycle performs first p_b round (o_round=12-NB_ROUNDS_B) with o_enable_xor_data_begin high; remaining NB_ROUNDS_B-1 rounds in *_PERM.
REQ-024 AD block last round: o_enable_xor_lsb_end high iff block carried i_data_last; next state PT_WAIT if last, else AD_WAIT.
REQ-025 PT accept: o_cipher_valid high that cycle; non-last -> PT_PERM then PT_WAIT.
REQ-026 Last PT accept: o_enable_xor_data_begin and o_enable_xor_key_begin both high, first p_a round (o_round=0), go FINAL.
REQ-027 FINAL: remaining NB_ROUNDS_A-1 rounds; last round asserts o_enable_xor_key_end; then DONE.
REQ-028 DONE: o_tag_valid=1 for one cycle, o_state_enable=0, return IDLE.
REQ-029 o_data_ready low outside *_WAIT; i_data_valid ignored there; i_start ignored outside IDLE.
REQ-030 Round counter 4-bit, increments to 11 then phase ends; never wraps past 11.
REQ-031 All enables/strobes are combinational Moore/Mealy decodes of state, counter and handshake; none asserted in IDLE.

Reset
REQ-032 i_reset_n low, any state including mid-permutation: state=IDLE, counter=0, has_ad=0, all outputs 0 asynchronously.
REQ-033 Deassertion takes effect at next rising edge; no start accepted in deassert cycle unless i_start high then.

Structure
REQ-034 ascon_pkg gains the state enum type t_fsm_state and constants for NB_ROUNDS_A/NB_ROUNDS_B defaults.
REQ-035 One sub-module ascon_round_counter: load value, enable, 4-bit count, terminal flag at 11.

Verification
REQ-036 No AD, one PT block valid ahead of time; start at edge 0 -> INIT rounds edges 1-12, key_end+lsb_end at 12, accept+cipher_valid+key_begin at 13, key_end at 24, tag_valid at 25, IDLE at 26.
REQ-037 Two AD blocks (second last), one PT -> data_begin at each accept, o_round 6..11 per block, lsb_end only on second block round 11.
REQ-038 PT_WAIT with i_data_valid low 5 cycles -> state/counter frozen, o_state_enable 0, o_data_ready 1 throughout.
REQ-039 i_reset_n low mid-FINAL (round 5) -> all outputs 0 immediately; new start afterwards reproduces REQ-036 timing.
REQ-040 i_start pulsed during AD_PERM, i_data_valid during INIT -> ignored; sequence timing unchanged.
